mem_port_arbiter: RTL

//  Shares one single-port unified memory between instruction fetch (IF) and the load/store
//  (D) path of the MIPS core. Serialises accesses through a wait-state FSM and

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the memory arbiter and the memory.
// The slave modport is the arbiter's view; master is the core plus memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic              If_Req;
  logic [ADDR_W-1:0] If_Addr;
  logic              If_Ack;
  logic [DATA_W-1:0] If_Data;
  logic              D_Req;
  logic              D_Write;
  logic [ADDR_W-1:0] D_Addr;
  logic [DATA_W-1:0] D_Wdata;
  logic              D_Ack;
  logic [DATA_W-1:0] D_Rdata;
  logic              Mem_En;
  logic              Mem_We;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Wdata;
  logic [DATA_W-1:0] Mem_Rdata;
  logic              Pc_Stall;

  modport slave (
    input  If_Req, If_Addr, D_Req, D_Write, D_Addr, D_Wdata, Mem_Rdata,
    output If_Ack, If_Data, D_Ack, D_Rdata, Mem_En, Mem_We, Mem_Addr, Mem_Wdata, Pc_Stall
  );

  modport master (
    output If_Req, If_Addr, D_Req, D_Write, D_Addr, D_Wdata, Mem_Rdata,
    input  If_Ack, If_Data, D_Ack, D_Rdata, Mem_En, Mem_We, Mem_Addr, Mem_Wdata, Pc_Stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and load/store accesses onto one multi-cycle memory port.
// Define MEM_ARB_STATS_EN to add a saturating Conflict_Count output.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       Conflict_Count
`endif
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned RUN_W = $clog2(MAX_DATA_RUN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = load/store path owns the access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              elig_if, elig_d, grant, pick_d;

  // Next-state, arbitration and output decode
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    elig_if   = 1'b0;
    elig_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        elig_if = bus.If_Req;
        elig_d  = bus.D_Req;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q) d_rdata_d = bus.Mem_Rdata;
            else         if_data_d = bus.Mem_Rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // The requester being acked still shows its old Req this cycle
        state_d = IDLE;
        elig_if = bus.If_Req & owner_q;
        elig_d  = bus.D_Req & ~owner_q;
      end
      default: state_d = IDLE;
    endcase

    grant  = elig_if | elig_d;
    pick_d = elig_d & ~(elig_if & (run_q == RUN_W'(MAX_DATA_RUN)));

    if (grant) begin
      state_d = ACCESS;
      owner_d = pick_d;
      we_d    = pick_d & bus.D_Write;
      addr_d  = pick_d ? bus.D_Addr : bus.If_Addr;
      cnt_d   = CNT_W'(MEM_LAT - 1);
      if (pick_d) wdata_d = bus.D_Wdata;
    end

    // Run of data grants that a waiting fetch has had to sit through
    if (!bus.If_Req) begin
      run_d = '0;
    end else if (grant && pick_d) begin
      if (run_q != RUN_W'(MAX_DATA_RUN)) run_d = run_q + RUN_W'(1);
    end else if (grant) begin
      run_d = '0;
    end

    mem_en_d = (state_d == ACCESS);
    mem_we_d = mem_en_d & we_d & owner_d;
    if_ack_d = (state_d == RESP) & ~owner_d;
    d_ack_d  = (state_d == RESP) & owner_d;
  end

  // State and output registers
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      run_q     <= '0;
      if_data_q <= '0;
      d_rdata_q <= '0;
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
      if_ack_q  <= if_ack_d;
      d_ack_q   <= d_ack_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign bus.If_Ack    = if_ack_q;
  assign bus.If_Data   = if_data_q;
  assign bus.D_Ack     = d_ack_q;
  assign bus.D_Rdata   = d_rdata_q;
  assign bus.Mem_En    = mem_en_q;
  assign bus.Mem_We    = mem_we_q;
  assign bus.Mem_Addr  = addr_q;
  assign bus.Mem_Wdata = wdata_q;
  assign bus.Pc_Stall  = bus.If_Req & ~if_ack_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] conf_q, conf_d;

  // Counts decisions where both requesters were eligible, saturating
  always_comb begin
    conf_d = conf_q;
    if (elig_if && elig_d && (conf_q != 16'hFFFF)) conf_d = conf_q + 16'd1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) conf_q <= '0;
    else          conf_q <= conf_d;
  end

  assign Conflict_Count = conf_q;
`endif

endmodule
